// File: rtl/fir_pkg.sv
// Shared FIR definitions.
// Purpose: keeps the filter and its output stage on the same default widths,
// and provides the round/shift/saturate helper used by the output stage.
// Contents:
//   W_X, W_K, N, W_Y, W_O  default filter and output widths
//   y_sample_t, out_sample_t  signed sample types at the default widths
//   round_sat()  round half toward +inf, arithmetic shift, clip to W_O bits
package fir_pkg;

    localparam int W_X = 8;
    localparam int W_K = 3;
    localparam int N   = 5;
    localparam int W_Y = 17;
    localparam int W_O = 8;

    typedef logic signed [W_Y-1:0] y_sample_t;
    typedef logic signed [W_O-1:0] out_sample_t;

    // value holds the clipped result sign-extended to 32 bits; callers keep
    // the low w_o bits.
    typedef struct packed {
        logic        sat;
        logic [31:0] value;
    } round_sat_t;

    // The working width is one bit wider than any supported input, so the
    // rounding add cannot wrap.
    function automatic round_sat_t round_sat(input logic signed [31:0] value,
                                             input int shift,
                                             input int w_o);
        logic signed [32:0] ext;
        logic signed [32:0] sum;
        logic signed [32:0] r;
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        round_sat_t         res;
        ext = {value[31], value};
        if (shift > 0) begin
            sum = ext + (33'sd1 <<< (shift - 1));
        end else begin
            sum = ext;
        end
        r     = sum >>> shift;
        max_v = (33'sd1 <<< (w_o - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (w_o - 1));
        res.sat   = 1'b0;
        res.value = r[31:0];
        if (r > max_v) begin
            res.sat   = 1'b1;
            res.value = max_v[31:0];
        end else if (r < min_v) begin
            res.sat   = 1'b1;
            res.value = min_v[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage.
// Purpose: small buffer between the output stage and a valid/ready consumer.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wr_data write request and data (ignored when full unless popping)
//   pop           read request (ignored when empty)
//   rd_data       head entry
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same edge, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage is written without reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage.
// Purpose: decimates the full-precision filter output by D, rounds and shifts
// it down to W_O bits with saturation, buffers the results and presents them
// on a valid/ready stream.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid, y       new filter sample this cycle
//   m_ready           consumer accepts m_data this cycle
//   m_valid, m_data   output stream (head of the FIFO)
//   sat               sticky: a kept sample was clipped
//   overflow          sticky: a kept sample was dropped on a full FIFO
module fir_decim_out #(
    parameter int W_Y   = fir_pkg::W_Y,
    parameter int W_O   = fir_pkg::W_O,
    parameter int SHIFT = 6,
    parameter int D     = 2,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic signed [W_Y-1:0] y,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic signed [W_O-1:0] m_data,
    output logic                  sat,
    output logic                  overflow
);

    import fir_pkg::*;

    localparam int PHASE_W = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [PHASE_W-1:0] phase;
    logic               keep;
    logic signed [31:0] y_wide;
    round_sat_t         rs;

    logic               stage_valid;
    logic [W_O-1:0]     stage_data;

    logic               fifo_pop;
    logic [W_O-1:0]     fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    assign keep   = in_valid && (phase == '0);
    assign y_wide = 32'(y);
    assign rs     = round_sat(y_wide, SHIFT, W_O);

    // Phase only moves on valid samples, so idle cycles never shift which
    // sample is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (in_valid) begin
            if (phase == PHASE_W'(D - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Stage register breaks the path from y to the FIFO; sat is flagged as
    // soon as the clipped sample is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
            sat         <= 1'b0;
        end else begin
            stage_valid <= keep;
            if (keep) begin
                stage_data <= rs.value[W_O-1:0];
                if (rs.sat) begin
                    sat <= 1'b1;
                end
            end
        end
    end

    // A full FIFO still accepts when the consumer pops in the same cycle, so
    // only a push without a pop counts as a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (stage_valid && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    assign fifo_pop = m_valid && m_ready;

    sync_fifo #(
        .WIDTH (W_O),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (stage_valid),
        .wr_data (stage_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Storage is not reset, so the head is masked to zero while empty.
    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : $signed(fifo_rd_data);

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed testbench for fir_decim_out at default parameters
// (W_Y=17, W_O=8, SHIFT=6, D=2, DEPTH=4). Expected values are hand-computed.
module tb_fir_decim_out;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [16:0] y;
    logic               m_ready;
    logic               m_valid;
    logic signed [7:0]  m_data;
    logic               sat;
    logic               overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic signed [7:0] got[$];

    fir_decim_out dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .y        (y),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .sat      (sat),
        .overflow (overflow)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Advance one cycle; inputs and samples are taken 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick and record any word delivered to the consumer this cycle.
    task automatic tick_collect();
        if (m_valid && m_ready) got.push_back(m_data);
        tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        y        = '0;
        m_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset m_valid got %b expected 0", m_valid);
        end
        tests_run++;
        if (m_data !== 8'sd0) begin
            tests_failed++;
            $display("[TB] FAIL reset m_data got %0d expected 0", m_data);
        end
        tests_run++;
        if (sat !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset flags got sat=%b overflow=%b expected 0 0", sat, overflow);
        end
    endtask

    task automatic test_rounding();
        int vals[5] = '{96, -96, 95, 31, 32};
        int exps[5] = '{2, -1, 1, 0, 1};
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            y        = 17'(vals[i]);
            tick();
            y = '0;
            tests_run++;
            if (m_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rounding_latency[%0d] m_valid got %b expected 0", i, m_valid);
            end
            tick();
            in_valid = 1'b0;
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== 8'(exps[i])) begin
                tests_failed++;
                $display("[TB] FAIL rounding[%0d] got valid=%b data=%0d expected valid=1 data=%0d",
                         i, m_valid, m_data, exps[i]);
            end
        end
        tick();
        tests_run++;
        if (sat !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rounding_sat got %b expected 0", sat);
        end
    endtask

    task automatic test_decimation();
        int exps[3] = '{0, 2, 4};
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            m_ready = 1'b1;
            got.delete();
            for (int i = 0; i < 6; i++) begin
                in_valid = 1'b1;
                y        = 17'(64 * i);
                tick_collect();
                if (pass == 1) begin
                    in_valid = 1'b0;
                    tick_collect();
                end
            end
            in_valid = 1'b0;
            repeat (5) tick_collect();
            tests_run++;
            if (got.size() != 3) begin
                tests_failed++;
                $display("[TB] FAIL decimation_count[pass %0d] got %0d outputs expected 3",
                         pass, got.size());
            end
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (k >= got.size()) begin
                    tests_failed++;
                    $display("[TB] FAIL decimation[pass %0d][%0d] got none expected %0d",
                             pass, k, exps[k]);
                end else if (got[k] !== 8'(exps[k])) begin
                    tests_failed++;
                    $display("[TB] FAIL decimation[pass %0d][%0d] got %0d expected %0d",
                             pass, k, got[k], exps[k]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int vals[3] = '{65535, -65536, 8191};
        int exps[3] = '{127, -128, 127};
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            y        = 17'(vals[i]);
            tick();
            y = '0;
            if (i == 0) begin
                tests_run++;
                if (sat !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL saturation_flag got %b expected 1", sat);
                end
            end
            tick();
            in_valid = 1'b0;
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== 8'(exps[i])) begin
                tests_failed++;
                $display("[TB] FAIL saturation[%0d] got valid=%b data=%0d expected valid=1 data=%0d",
                         i, m_valid, m_data, exps[i]);
            end
        end
        tick();
        tests_run++;
        if (sat !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL saturation_sticky got %b expected 1", sat);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1;
            y        = 17'(64 * k);
            tick();
            y = '0;
            tick();
            in_valid = 1'b0;
            if (k == 4 || k == 5) begin
                tests_run++;
                if (overflow !== (k == 5)) begin
                    tests_failed++;
                    $display("[TB] FAIL backpressure_overflow[%0d] got %b expected %b",
                             k, overflow, (k == 5));
                end
            end
        end
        repeat (3) tick();
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'sd1 || overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_hold got valid=%b data=%0d overflow=%b expected 1 1 1",
                     m_valid, m_data, overflow);
        end
        m_ready = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== 8'(e)) begin
                tests_failed++;
                $display("[TB] FAIL backpressure_drain[%0d] got valid=%b data=%0d expected valid=1 data=%0d",
                         e, m_valid, m_data, e);
            end
            tick();
        end
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_empty m_valid got %b expected 0", m_valid);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            y        = 17'(64 * k);
            tick();
            y = '0;
            tick();
            in_valid = 1'b0;
        end
        repeat (2) tick();
        // Sample 5 reaches the stage register while the FIFO is full.
        in_valid = 1'b1;
        y        = 17'sd320;
        tick();
        in_valid = 1'b0;
        y        = '0;
        m_ready  = 1'b1;
        tests_run++;
        if (m_data !== 8'sd1) begin
            tests_failed++;
            $display("[TB] FAIL full_pop_head got %0d expected 1", m_data);
        end
        tick();
        m_ready = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_pop_overflow got %b expected 0", overflow);
        end
        tick();
        m_ready = 1'b1;
        for (int e = 2; e <= 5; e++) begin
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== 8'(e)) begin
                tests_failed++;
                $display("[TB] FAIL full_pop_order[%0d] got valid=%b data=%0d expected valid=1 data=%0d",
                         e, m_valid, m_data, e);
            end
            tick();
        end
        tests_run++;
        if (m_valid !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_pop_end got valid=%b overflow=%b expected 0 0", m_valid, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int vals[5] = '{65535, 64, 128, 192, 256};
        do_reset();
        m_ready = 1'b0;
        // Last kept sample has no follower, leaving phase at 1.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            y        = 17'(vals[i]);
            tick();
            if (i < 4) begin
                y = '0;
                tick();
            end
        end
        in_valid = 1'b0;
        y        = '0;
        repeat (3) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tests_run++;
        if (sat !== 1'b1 || overflow !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'sd1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_before got sat=%b overflow=%b valid=%b data=%0d expected 1 1 1 1",
                     sat, overflow, m_valid, m_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (m_valid !== 1'b0 || m_data !== 8'sd0 || sat !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_after got valid=%b data=%0d sat=%b overflow=%b expected 0 0 0 0",
                     m_valid, m_data, sat, overflow);
        end
        m_ready  = 1'b1;
        in_valid = 1'b1;
        y        = 17'sd96;
        tick();
        in_valid = 1'b0;
        y        = '0;
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_latency m_valid got %b expected 0", m_valid);
        end
        tick();
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'sd2) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_first got valid=%b data=%0d expected valid=1 data=2",
                     m_valid, m_data);
        end
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        y        = '0;
        m_ready  = 1'b0;
        test_reset();
        test_rounding();
        test_decimation();
        test_saturation();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
